// File: rtl/mb_access_scheduler.sv
// Round-robin dual-port access scheduler in front of memory_top, with read-tag tracking per port.
// Optional same-address A/B hazard blocking is enabled by defining MB_SCHED_ADDR_HAZARD_EN.
module mb_access_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_ena,
    output logic                          o_wea,
    output logic                          o_enb,
    output logic                          o_web,
    output logic [ADDR_WIDTH-1:0]         o_addra,
    output logic [ADDR_WIDTH-1:0]         o_addrb,
    output logic [DATA_WIDTH-1:0]         o_data_in_a,
    output logic [DATA_WIDTH-1:0]         o_data_in_b,
    input  logic [DATA_WIDTH-1:0]         i_dout_a,
    input  logic [DATA_WIDTH-1:0]         i_dout_b,
    output logic                          o_rsp_valid_a,
    output logic                          o_rsp_valid_b,
    output logic [ID_W-1:0]               o_rsp_id_a,
    output logic [ID_W-1:0]               o_rsp_id_b,
    output logic [DATA_WIDTH-1:0]         o_rsp_data_a,
    output logic [DATA_WIDTH-1:0]         o_rsp_data_b
);

    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       scan_id_s [NUM_REQ];
    logic                  found_a_s, found_b_s, hazard_s, grant_b_s;
    logic [ID_W-1:0]       id_a_s, id_b_s;
    logic                  we_a_s, we_b_s;
    logic [ADDR_WIDTH-1:0] addr_a_s, addr_b_s;
    logic [DATA_WIDTH-1:0] wdata_a_s, wdata_b_s;

    logic                  ena_q, wea_q, enb_q, web_q;
    logic [ADDR_WIDTH-1:0] addra_q, addrb_q;
    logic [DATA_WIDTH-1:0] din_a_q, din_b_q;
    logic [RD_LATENCY:0]           tag_v_a_q, tag_v_b_q;
    logic [RD_LATENCY:0][ID_W-1:0] tag_id_a_q, tag_id_b_q;
    logic                  rsp_v_a_q, rsp_v_b_q;
    logic [ID_W-1:0]       rsp_id_a_q, rsp_id_b_q;
    logic [DATA_WIDTH-1:0] rsp_d_a_q, rsp_d_b_q;

    // Requester IDs in scan order starting at the round-robin pointer.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_id_s[i] = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
        end
    end

    // First and second valid requesters in scan order become the A and B candidates.
    always_comb begin
        found_a_s = 1'b0;
        found_b_s = 1'b0;
        id_a_s    = '0;
        id_b_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[scan_id_s[i]] && !found_a_s) begin
                found_a_s = 1'b1;
                id_a_s    = scan_id_s[i];
            end else if (i_req_valid[scan_id_s[i]] && !found_b_s) begin
                found_b_s = 1'b1;
                id_b_s    = scan_id_s[i];
            end else begin
                found_b_s = found_b_s;
            end
        end
    end

    // Candidate request fields, hazard decision and final B grant.
    always_comb begin
        we_a_s    = i_req_we[id_a_s];
        we_b_s    = i_req_we[id_b_s];
        addr_a_s  = i_req_addr[int'(id_a_s)*ADDR_WIDTH +: ADDR_WIDTH];
        addr_b_s  = i_req_addr[int'(id_b_s)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_a_s = i_req_wdata[int'(id_a_s)*DATA_WIDTH +: DATA_WIDTH];
        wdata_b_s = i_req_wdata[int'(id_b_s)*DATA_WIDTH +: DATA_WIDTH];
`ifdef MB_SCHED_ADDR_HAZARD_EN
        hazard_s  = found_b_s && (addr_a_s == addr_b_s) && (we_a_s || we_b_s);
`else
        hazard_s  = 1'b0;
`endif
        grant_b_s = found_b_s && !hazard_s;
    end

    // Ready is asserted only for granted requesters; a blocked B keeps its place in the scan.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            o_req_ready[k] = (found_a_s && (id_a_s == ID_W'(k))) ||
                             (grant_b_s && (id_b_s == ID_W'(k)));
        end
        if (grant_b_s) begin
            rr_ptr_d = ID_W'((int'(id_b_s) + 1) % NUM_REQ);
        end else if (found_a_s) begin
            rr_ptr_d = ID_W'((int'(id_a_s) + 1) % NUM_REQ);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Pointer, port registers, read-tag pipelines and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            ena_q      <= 1'b0;
            wea_q      <= 1'b0;
            enb_q      <= 1'b0;
            web_q      <= 1'b0;
            addra_q    <= '0;
            addrb_q    <= '0;
            din_a_q    <= '0;
            din_b_q    <= '0;
            tag_v_a_q  <= '0;
            tag_v_b_q  <= '0;
            tag_id_a_q <= '0;
            tag_id_b_q <= '0;
            rsp_v_a_q  <= 1'b0;
            rsp_v_b_q  <= 1'b0;
            rsp_id_a_q <= '0;
            rsp_id_b_q <= '0;
            rsp_d_a_q  <= '0;
            rsp_d_b_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            ena_q    <= found_a_s;
            wea_q    <= found_a_s && we_a_s;
            enb_q    <= grant_b_s;
            web_q    <= grant_b_s && we_b_s;
            if (found_a_s) begin
                addra_q <= addr_a_s;
                din_a_q <= wdata_a_s;
            end
            if (grant_b_s) begin
                addrb_q <= addr_b_s;
                din_b_q <= wdata_b_s;
            end
            tag_v_a_q  <= {tag_v_a_q[RD_LATENCY-1:0], found_a_s && !we_a_s};
            tag_v_b_q  <= {tag_v_b_q[RD_LATENCY-1:0], grant_b_s && !we_b_s};
            tag_id_a_q <= {tag_id_a_q[RD_LATENCY-1:0], id_a_s};
            tag_id_b_q <= {tag_id_b_q[RD_LATENCY-1:0], id_b_s};
            rsp_v_a_q  <= tag_v_a_q[RD_LATENCY];
            rsp_v_b_q  <= tag_v_b_q[RD_LATENCY];
            if (tag_v_a_q[RD_LATENCY]) begin
                rsp_id_a_q <= tag_id_a_q[RD_LATENCY];
                rsp_d_a_q  <= i_dout_a;
            end
            if (tag_v_b_q[RD_LATENCY]) begin
                rsp_id_b_q <= tag_id_b_q[RD_LATENCY];
                rsp_d_b_q  <= i_dout_b;
            end
        end
    end

    assign o_ena         = ena_q;
    assign o_wea         = wea_q;
    assign o_enb         = enb_q;
    assign o_web         = web_q;
    assign o_addra       = addra_q;
    assign o_addrb       = addrb_q;
    assign o_data_in_a   = din_a_q;
    assign o_data_in_b   = din_b_q;
    assign o_rsp_valid_a = rsp_v_a_q;
    assign o_rsp_valid_b = rsp_v_b_q;
    assign o_rsp_id_a    = rsp_id_a_q;
    assign o_rsp_id_b    = rsp_id_b_q;
    assign o_rsp_data_a  = rsp_d_a_q;
    assign o_rsp_data_b  = rsp_d_b_q;

endmodule

// File: tb/tb_mb_access_scheduler.sv
// Bench for mb_access_scheduler: memory stand-in, queue-based arbitration model and directed literal checks.
module tb_mb_access_scheduler;
    localparam int N   = 4;
    localparam int DW  = 12;
    localparam int AW  = 8;
    localparam int RDL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    req_valid, req_we, req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            ena, wea, enb, web;
    logic [AW-1:0]   addra, addrb;
    logic [DW-1:0]   dina, dinb, dout_a, dout_b;
    logic            rva, rvb;
    logic [1:0]      rida, ridb;
    logic [DW-1:0]   rda, rdb;

    int n_cmp  = 0;
    int n_fail = 0;
    bit done   = 1'b0;

    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] pipe_a [0:RDL-1];
    logic [DW-1:0] pipe_b [0:RDL-1];

    always #5 clk = ~clk;

    mb_access_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_ready(req_ready),
        .o_ena(ena), .o_wea(wea), .o_enb(enb), .o_web(web),
        .o_addra(addra), .o_addrb(addrb), .o_data_in_a(dina), .o_data_in_b(dinb),
        .i_dout_a(dout_a), .i_dout_b(dout_b),
        .o_rsp_valid_a(rva), .o_rsp_valid_b(rvb), .o_rsp_id_a(rida), .o_rsp_id_b(ridb),
        .o_rsp_data_a(rda), .o_rsp_data_b(rdb)
    );

    // memory_top stand-in: read-first dual port, RDL-cycle read latency, port B write wins a collision
    always @(posedge clk) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            else     pipe_a[0]  <= mem[addra];
        end
        if (enb) begin
            if (web) mem[addrb] <= dinb;
            else     pipe_b[0]  <= mem[addrb];
        end
        for (int k = 1; k < RDL; k++) begin
            pipe_a[k] <= pipe_a[k-1];
            pipe_b[k] <= pipe_b[k-1];
        end
    end
    assign dout_a = pipe_a[RDL-1];
    assign dout_b = pipe_b[RDL-1];

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'((a * 37 + 5) % 4096);
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = init_val(i);
            shadow[i] = init_val(i);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Round robin as a list: valid IDs collected in scan order, first two take A and B.
    task automatic arbitrate(input int rr, output int a, output int b);
        int q[$];
        for (int i = 0; i < N; i++) begin
            if (req_valid[(rr + i) % N]) q.push_back((rr + i) % N);
        end
        a = (q.size() > 0) ? q[0] : -1;
        b = (q.size() > 1) ? q[1] : -1;
`ifdef MB_SCHED_ADDR_HAZARD_EN
        if (b >= 0 && req_addr[a*AW +: AW] == req_addr[b*AW +: AW] && (req_we[a] || req_we[b])) b = -1;
`endif
    endtask

    initial begin : compare
        int rr_m = 0;
        int cyc  = 0;
        int ga, gb;
        logic ena_m = 1'b0, wea_m = 1'b0, enb_m = 1'b0, web_m = 1'b0;
        logic [AW-1:0] aa_m = '0, ab_m = '0;
        logic [DW-1:0] da_m = '0, db_m = '0;
        logic [N-1:0]  rdy_m;
        int xid_a [int];
        int xd_a  [int];
        int xid_b [int];
        int xd_b  [int];
        int pw_addr[$];
        int pw_data[$];
        forever begin
            @(negedge clk);
            if (done) break;
            cyc++;
            if (rst) begin
                chk("rst_ena", ena, 0);   chk("rst_wea", wea, 0);
                chk("rst_enb", enb, 0);   chk("rst_web", web, 0);
                chk("rst_addra", addra, 0); chk("rst_addrb", addrb, 0);
                chk("rst_dina", dina, 0); chk("rst_dinb", dinb, 0);
                chk("rst_rva", rva, 0);   chk("rst_rvb", rvb, 0);
                chk("rst_rida", rida, 0); chk("rst_ridb", ridb, 0);
                chk("rst_rda", rda, 0);   chk("rst_rdb", rdb, 0);
                rr_m = 0;
                ena_m = 1'b0; wea_m = 1'b0; enb_m = 1'b0; web_m = 1'b0;
                aa_m = '0; ab_m = '0; da_m = '0; db_m = '0;
                xid_a.delete(); xd_a.delete(); xid_b.delete(); xd_b.delete();
                pw_addr.delete(); pw_data.delete();
                arbitrate(rr_m, ga, gb);
                rdy_m = '0;
                if (ga >= 0) rdy_m[ga] = 1'b1;
                if (gb >= 0) rdy_m[gb] = 1'b1;
                chk("ready_in_rst", req_ready, rdy_m);
            end else begin
                chk("ena", ena, ena_m);     chk("wea", wea, wea_m);
                chk("enb", enb, enb_m);     chk("web", web, web_m);
                chk("addra", addra, aa_m);  chk("addrb", addrb, ab_m);
                chk("dina", dina, da_m);    chk("dinb", dinb, db_m);
                chk("rsp_valid_a", rva, 32'(xid_a.exists(cyc)));
                chk("rsp_valid_b", rvb, 32'(xid_b.exists(cyc)));
                if (xid_a.exists(cyc)) begin
                    chk("rsp_id_a", rida, xid_a[cyc]);
                    chk("rsp_data_a", rda, xd_a[cyc]);
                end
                if (xid_b.exists(cyc)) begin
                    chk("rsp_id_b", ridb, xid_b[cyc]);
                    chk("rsp_data_b", rdb, xd_b[cyc]);
                end
                // writes granted last cycle land in memory at the end of this cycle's predecessor port slot
                foreach (pw_addr[i]) shadow[pw_addr[i]] = DW'(pw_data[i]);
                pw_addr.delete(); pw_data.delete();
                arbitrate(rr_m, ga, gb);
                rdy_m = '0;
                if (ga >= 0) rdy_m[ga] = 1'b1;
                if (gb >= 0) rdy_m[gb] = 1'b1;
                chk("ready", req_ready, rdy_m);
                ena_m = (ga >= 0);
                enb_m = (gb >= 0);
                wea_m = 1'b0;
                web_m = 1'b0;
                if (ga >= 0) begin
                    wea_m = req_we[ga];
                    aa_m  = req_addr[ga*AW +: AW];
                    da_m  = req_wdata[ga*DW +: DW];
                    if (req_we[ga]) begin
                        pw_addr.push_back(int'(aa_m)); pw_data.push_back(int'(da_m));
                    end else begin
                        xid_a[cyc+2+RDL] = ga; xd_a[cyc+2+RDL] = int'(shadow[aa_m]);
                    end
                end
                if (gb >= 0) begin
                    web_m = req_we[gb];
                    ab_m  = req_addr[gb*AW +: AW];
                    db_m  = req_wdata[gb*DW +: DW];
                    if (req_we[gb]) begin
                        pw_addr.push_back(int'(ab_m)); pw_data.push_back(int'(db_m));
                    end else begin
                        xid_b[cyc+2+RDL] = gb; xd_b[cyc+2+RDL] = int'(shadow[ab_m]);
                    end
                end
                if (gb >= 0)      rr_m = (gb + 1) % N;
                else if (ga >= 0) rr_m = (ga + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[k]        = 1'b1;
        req_we[k]           = we;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    initial begin : stim
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init_ena", ena, 0); chk("init_rva", rva, 0); chk("init_ready", req_ready, 0);
        step(); rst = 1'b0;

        // single read by requester 2
        set_req(2, 1'b0, 8'h45, 12'h000);
        @(negedge clk); chk("t1_ready", req_ready, 4'b0100);
        step(); clear_req();
        @(negedge clk); chk("t1_ena", ena, 1); chk("t1_addra", addra, 8'h45); chk("t1_enb", enb, 0);
        repeat (1 + RDL) step();
        @(negedge clk);
        chk("t1_rsp_valid", rva, 1); chk("t1_rsp_id", rida, 2); chk("t1_rsp_data", rda, 12'h9FE);
        chk("t1_rsp_valid_b", rvb, 0);
        step(); req_valid = '1; req_we = '0;
        @(negedge clk); chk("t1_rr_is_3", req_ready, 4'b1001);
        step(); clear_req(); rst = 1'b1;
        step(); rst = 1'b0;

        // all four requesters continuously valid
        req_valid = '1; req_we = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("t2_ready", req_ready, (i % 2 == 0) ? 4'b0011 : 4'b1100);
            step();
        end

        // write then read by requester 1
        clear_req(); set_req(1, 1'b1, 8'h10, 12'h3A5);
        @(negedge clk); chk("t3_wr_ready", req_ready, 4'b0010);
        step(); clear_req(); set_req(1, 1'b0, 8'h10, 12'h000);
        @(negedge clk);
        chk("t3_rd_ready", req_ready, 4'b0010); chk("t3_wr_ena", ena, 1); chk("t3_wr_wea", wea, 1);
        chk("t3_wr_addr", addra, 8'h10); chk("t3_wr_data", dina, 12'h3A5);
        step(); clear_req();
        @(negedge clk); chk("t3_rd_wea", wea, 0);
        repeat (RDL) step();
        @(negedge clk); chk("t3_no_wr_rsp", rva, 0);
        step();
        @(negedge clk);
        chk("t3_rsp_valid", rva, 1); chk("t3_rsp_id", rida, 1); chk("t3_rsp_data", rda, 12'h3A5);

        // requesters 0 and 3 write the same address
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        clear_req(); set_req(0, 1'b1, 8'h20, 12'h111); set_req(3, 1'b1, 8'h20, 12'h333);
`ifdef MB_SCHED_ADDR_HAZARD_EN
        @(negedge clk); chk("t4_ready_hz", req_ready, 4'b0001);
        step(); req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t4_ready_next", req_ready, 4'b1000); chk("t4_ena", ena, 1);
        chk("t4_dina", dina, 12'h111); chk("t4_enb", enb, 0);
        step(); clear_req();
        @(negedge clk); chk("t4_ena2", ena, 1); chk("t4_dina2", dina, 12'h333);
`else
        @(negedge clk); chk("t4_ready", req_ready, 4'b1001);
        step(); clear_req();
        @(negedge clk);
        chk("t4_ena", ena, 1); chk("t4_dina", dina, 12'h111);
        chk("t4_enb", enb, 1); chk("t4_addrb", addrb, 8'h20); chk("t4_dinb", dinb, 12'h333);
`endif

        // reset while reads are in flight on both ports
        step(); clear_req();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'($urandom_range(1, 255)), 12'h000);
        @(negedge clk);
        step();
        @(negedge clk);
        step(); clear_req(); rst = 1'b1;
        @(negedge clk);
        chk("t5_ena", ena, 0); chk("t5_enb", enb, 0); chk("t5_addra", addra, 0); chk("t5_addrb", addrb, 0);
        chk("t5_rva", rva, 0); chk("t5_rvb", rvb, 0); chk("t5_rda", rda, 0); chk("t5_rida", rida, 0);
        step(); rst = 1'b0; req_valid = '1; req_we = '0;
        @(negedge clk); chk("t5_first_grant", req_ready, 4'b0011);
        chk("t5_rva0", rva, 0); chk("t5_rvb0", rvb, 0);
        step(); clear_req();
        for (int i = 0; i < 1 + RDL; i++) begin
            @(negedge clk); chk("t5_no_rsp_a", rva, 0); chk("t5_no_rsp_b", rvb, 0);
            step();
        end

        // randomized traffic with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            rst = (c % 700 == 350);
            req_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                req_we[k]             = ($urandom_range(0, 2) == 0);
                req_addr[k*AW +: AW]  = AW'($urandom_range(0, 7));
                req_wdata[k*DW +: DW] = DW'($urandom);
            end
            step();
        end
        rst = 1'b0; clear_req();
        repeat (4 + RDL) step();
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end
endmodule
